// File: rtl/panel_shifter.sv
// Purpose: scan driver for a HUB75-style LED panel; fetches pixels and shifts them out row by row.
// Latency: rd_addr -> rgb 2 cycles; outputs are registered and trail the internal FSM by one cycle.
// Backpressure: none; free-running once enabled, en is only consulted when a new row is about to start.
//
// Ports:
//   clk_in, rst_in     sole clock; synchronous active-high reset
//   en                 scan enable, sampled at IDLE and at the end of each row
//   rd_addr            frame-buffer read address {row, col}
//   pix_data           {r1,g1,b1,r2,g2,b2}, valid one cycle after rd_addr
//   rgb, sclk, lat     panel colour lines, shift clock, latch
//   oe_n, mux          panel output enable (active low), row address
//   frame_start        one-cycle pulse at the start of row 0 shifting
module panel_shifter #(
    parameter int COL_BITS    = 6,
    parameter int ROW_BITS    = 4,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         en,
    output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
    input  logic [5:0]                   pix_data,
    output logic [5:0]                   rgb,
    output logic                         sclk,
    output logic                         lat,
    output logic                         oe_n,
    output logic [ROW_BITS-1:0]          mux,
    output logic                         frame_start
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, HOLD} state_t;

    state_t              state;
    logic [COL_BITS-1:0] col;        // slot index within the row, wraps to 0 entering the extra slot
    logic                tail;       // set during the extra slot COLS that only clocks out the last pixel
    logic                ph;         // 0 = fetch phase, 1 = shift-clock phase (also counts BLANK cycles)
    logic [ROW_BITS-1:0] shift_row;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                latched;    // panel holds real data, so lighting it is allowed

    logic in_shift;
    logic clk_slot;                  // slots 1..COLS carry a shift-clock edge

    assign in_shift = (state == SHIFT);
    assign clk_slot = (col != '0) || tail;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            col         <= '0;
            tail        <= 1'b0;
            ph          <= 1'b0;
            shift_row   <= '0;
            hold_cnt    <= '0;
            latched     <= 1'b0;
            rd_addr     <= '0;
            rgb         <= '0;
            sclk        <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            mux         <= '0;
            frame_start <= 1'b0;
        end else begin
            // Pins describe the cycle the FSM is in now, so they appear one cycle later.
            sclk        <= in_shift && ph && clk_slot;
            lat         <= (state == LATCH);
            oe_n        <= !(latched && (in_shift || state == HOLD));
            frame_start <= in_shift && !ph && !tail && (col == '0) && (shift_row == '0);

            // In the extra slot the address simply holds its last value.
            if (in_shift && !ph && !tail) begin
                rd_addr <= {shift_row, col};
            end
            // pix_data seen here answers the fetch of the previous slot.
            if (in_shift && !ph && clk_slot) begin
                rgb <= pix_data;
            end
            if (state == LATCH) begin
                mux <= shift_row;
            end else if (state == IDLE) begin
                mux <= '0;
            end

            case (state)
                IDLE: begin
                    shift_row <= '0;
                    latched   <= 1'b0;
                    if (en) begin
                        state <= SHIFT;
                        col   <= '0;
                        tail  <= 1'b0;
                        ph    <= 1'b0;
                    end
                end
                SHIFT: begin
                    ph <= !ph;
                    if (ph) begin
                        if (tail) begin
                            state <= BLANK;
                            tail  <= 1'b0;
                        end else begin
                            col <= col + 1'b1;
                            if (col == '1) begin
                                tail <= 1'b1;
                            end
                        end
                    end
                end
                BLANK: begin
                    // Two cycles: ph goes 0 -> 1 -> back to 0 ready for the next row.
                    ph <= !ph;
                    if (ph) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    latched   <= 1'b1;
                    shift_row <= shift_row + 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else if (en) begin
                        state <= SHIFT;
                    end else begin
                        state     <= IDLE;
                        shift_row <= '0;
                        latched   <= 1'b0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (en) begin
                            state <= SHIFT;
                        end else begin
                            state     <= IDLE;
                            shift_row <= '0;
                            latched   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_panel_shifter.sv
// Purpose: self-checking bench for panel_shifter (default build plus a HOLD_CYCLES=10 build).
// Latency: expectations are queued ahead of time and consumed as sclk edges and lat pulses appear.
// Backpressure: none; the bench bounds every wait and reports expiry as a failed comparison.
module tb_panel_shifter;
    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] rd_addr;
    logic [5:0] pix_data;
    logic [5:0] rgb;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic [3:0] mux;
    logic       frame_start;

    logic       rst_h;
    logic       en_h;
    logic [9:0] rd_addr_h;
    logic [5:0] pix_h;
    logic [5:0] rgb_h;
    logic       sclk_h;
    logic       lat_h;
    logic       oe_n_h;
    logic [3:0] mux_h;
    logic       frame_start_h;

    panel_shifter dut (
        .clk_in(clk), .rst_in(rst), .en(en), .rd_addr(rd_addr), .pix_data(pix_data),
        .rgb(rgb), .sclk(sclk), .lat(lat), .oe_n(oe_n), .mux(mux), .frame_start(frame_start)
    );

    panel_shifter #(.HOLD_CYCLES(10)) dut_h (
        .clk_in(clk), .rst_in(rst_h), .en(en_h), .rd_addr(rd_addr_h), .pix_data(pix_h),
        .rgb(rgb_h), .sclk(sclk_h), .lat(lat_h), .oe_n(oe_n_h), .mux(mux_h),
        .frame_start(frame_start_h)
    );

    typedef struct packed {
        logic [5:0] rgb;
        logic       oe_n;
    } exp_t;

    exp_t exp_q[$];
    int   mux_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor bookkeeping (the stimulus clears some of it around resets and idles).
    int   cyc = 0;
    int   lat_seen = 0;
    int   edges = 0;
    int   rows_since = 0;
    int   row0_oe_lo = 0;
    int   both_hi = 0;
    int   last_fs = 0;
    bit   last_fs_ok = 0;
    logic sclk_prev = 1'b0;
    logic oe_p1 = 1'b1;
    logic oe_p2 = 1'b1;
    bit   hold_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sclk"}, int'(sclk), 0);
        check({tag, "_lat"}, int'(lat), 0);
        check({tag, "_oe_n"}, int'(oe_n), 1);
        check({tag, "_mux"}, int'(mux), 0);
        check({tag, "_rgb"}, int'(rgb), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    // One row: 64 shift edges carrying columns 0..63, oe_n dark only on the first row after start.
    task automatic push_row(input int row, input logic first, input bit with_lat);
        exp_t e;
        for (int k = 1; k <= 64; k++) begin
            e.rgb  = 6'(k - 1);
            e.oe_n = first;
            exp_q.push_back(e);
        end
        if (with_lat) mux_q.push_back(row % 16);
    endtask

    task automatic clear_track();
        exp_q.delete();
        mux_q.delete();
        edges      = 0;
        rows_since = 0;
        row0_oe_lo = 0;
        last_fs_ok = 0;
    endtask

    task automatic wait_lats(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (lat_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_lat_count"}, lat_seen, target);
    endtask

    task automatic wait_addr(input int addr, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(rd_addr) != addr && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_addr_reached"}, int'(rd_addr), addr);
    endtask

    task automatic check_start(input string tag);
        @(posedge clk); #1;
        check({tag, "_fs_edge1"}, int'(frame_start), 0);
        @(posedge clk); #1;
        check({tag, "_fs_edge2"}, int'(frame_start), 1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer model: returns the low 6 bits of the address presented one cycle earlier.
    initial begin
        logic [9:0] last_addr;
        last_addr = '0;
        pix_data  = '0;
        forever begin
            @(posedge clk); #1;
            pix_data  = last_addr[5:0];
            last_addr = rd_addr;
        end
    end

    // Monitor: pops an expectation on every sclk rise and every lat pulse.
    initial begin
        exp_t e;
        int   m;
        forever begin
            @(negedge clk);
            cyc++;
            if (sclk && lat) both_hi++;
            if (rows_since == 0 && !oe_n) row0_oe_lo++;
            if (sclk && !sclk_prev) begin
                edges++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sclk", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rgb_at_sclk", int'(rgb), int'(e.rgb));
                    check("oe_n_at_sclk", int'(oe_n), int'(e.oe_n));
                end
            end
            if (frame_start) begin
                check("fs_rd_addr", int'(rd_addr), 0);
                if (last_fs_ok) check("fs_period", cyc - last_fs, 16 * 133);
                last_fs    = cyc;
                last_fs_ok = 1;
            end
            if (lat) begin
                lat_seen++;
                if (mux_q.size() == 0) begin
                    check("unexpected_lat", 1, 0);
                end else begin
                    m = mux_q.pop_front();
                    check("lat_mux", int'(mux), m);
                    if (m == 0 && last_fs_ok) check("fs_to_lat", cyc - last_fs, 132);
                end
                check("row_sclk_edges", edges, 64);
                check("lat_oe_n", int'(oe_n), 1);
                check("blank_oe_n", int'(oe_p1 & oe_p2), 1);
                if (rows_since == 0) check("row0_oe_n_low_cycles", row0_oe_lo, 0);
                edges = 0;
                rows_since++;
            end
            oe_p2     = oe_p1;
            oe_p1     = oe_n;
            sclk_prev = sclk;
        end
    end

    // HOLD_CYCLES=10 build: 143-cycle rows, lit and unclocked throughout HOLD.
    initial begin
        int n;
        rst_h = 1'b1;
        en_h  = 1'b1;
        pix_h = '0;
        repeat (3) @(posedge clk);
        #1 rst_h = 1'b0;
        n = 0;
        while (!lat_h && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("hold_first_lat", int'(lat_h), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            check("hold_oe_n", int'(oe_n_h), 0);
            check("hold_sclk", int'(sclk_h), 0);
        end
        do begin
            @(negedge clk);
            n++;
        end while (!lat_h && n < 400);
        check("hold_row_period", n, 143);
        hold_done = 1;
    end

    initial begin
        int base;
        int n;
        rst = 1'b1;
        en  = 1'b0;

        // Reset state, then release with en already high.
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");
        for (int r = 0; r < 17; r++) push_row(r, (r == 0), 1);
        en  = 1'b1;
        rst = 1'b0;
        check_start("start");

        // Sixteen rows plus the wrap back to row 0.
        wait_lats(17, 17 * 133 + 50, "wrap");
        check("wrap_exp_drained", exp_q.size(), 0);
        check("wrap_mux_drained", mux_q.size(), 0);

        // Reset pulse landing on the latch cycle.
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_latch");
        clear_track();
        for (int r = 0; r < 5; r++) push_row(r, (r == 0), 1);
        push_row(5, 1'b0, 0);
        rst = 1'b0;
        check_start("restart1");

        // Reset pulse in the middle of row 5 shifting (column 40).
        base = lat_seen;
        wait_lats(base + 5, 5 * 133 + 50, "mid");
        wait_addr(5 * 64 + 40, 400, "mid");
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_shift");
        clear_track();
        for (int r = 0; r < 4; r++) push_row(r, (r == 0), 1);
        rst = 1'b0;
        check_start("restart2");

        // Drop en at column 20 of row 3; the row must still finish and latch.
        base = lat_seen;
        wait_addr(3 * 64 + 20, 4 * 133 + 50, "endrop");
        en = 1'b0;
        wait_lats(base + 4, 200, "endrop");
        repeat (4) @(negedge clk);
        #1;
        check("idle_oe_n", int'(oe_n), 1);
        check("idle_mux", int'(mux), 0);
        check("idle_sclk", int'(sclk), 0);
        check("idle_exp_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        #1;
        check("idle_no_extra_lat", lat_seen, base + 4);

        // Resume: a fresh frame from row 0, unlit until latched again.
        clear_track();
        push_row(0, 1'b1, 1);
        base = lat_seen;
        en = 1'b1;
        n = 0;
        while (!frame_start && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("resume_frame_start", int'(frame_start), 1);
        wait_lats(base + 1, 200, "resume");
        check("resume_exp_drained", exp_q.size(), 0);
        check("sclk_lat_overlap", both_hi, 0);

        n = 0;
        while (!hold_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("hold_bench_done", int'(hold_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
